// File: rtl/vedic_mul_seq_ctrl.sv
// vedic_mul_seq_ctrl: sequences one external combinational 8x8 multiplier to
// build either a 32x32->64 scalar product (16 byte-pair steps) or four
// independent 8x8->16 lane products (4 steps), with valid/ready on both sides.
module vedic_mul_seq_ctrl #(
  parameter bit REG_PRODUCT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        vec_mode,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic        vec_q;
  logic [3:0]  k_q, k_d;
  logic [63:0] acc_q, acc_d;

  logic        accept, last_step;
  logic [1:0]  ai, bj;
  logic [2:0]  issue_sel;

  // product actually applied to the accumulator this cycle
  logic        app_en;
  logic [15:0] app_p;
  logic [2:0]  app_sel;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = vec_q ? (k_q == 4'd3) : (k_q == 4'd15);

  // Scalar: A byte from k[3:2], B byte from k[1:0]; vector: both from k[1:0].
  // issue_sel is the byte shift (i+j) in scalar mode, the lane index in vector.
  assign ai        = vec_q ? k_q[1:0] : k_q[3:2];
  assign bj        = k_q[1:0];
  assign issue_sel = vec_q ? {1'b0, k_q[1:0]}
                           : ({1'b0, k_q[3:2]} + {1'b0, k_q[1:0]});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = ISSUE;
      ISSUE:   if (last_step) state_d = REG_PRODUCT ? DRAIN : DONE;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; result only visible while out_valid
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = 8'd0;
    mul_b     = 8'd0;
    result    = 64'd0;
    unique case (state_q)
      IDLE:  in_ready = 1'b1;
      ISSUE: begin
        busy  = 1'b1;
        mul_a = a_q[{ai, 3'b000} +: 8];
        mul_b = b_q[{bj, 3'b000} +: 8];
      end
      DRAIN: busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        result    = acc_q;
      end
      default: ;
    endcase
  end

  generate
    if (REG_PRODUCT) begin : g_reg
      logic        en_q;
      logic [15:0] p_q;
      logic [2:0]  sel_q;
      // Capture product and its placement in the issue cycle, apply next cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          en_q  <= 1'b0;
          p_q   <= 16'd0;
          sel_q <= 3'd0;
        end else begin
          en_q  <= (state_q == ISSUE);
          p_q   <= mul_p;
          sel_q <= issue_sel;
        end
      end
      assign app_en  = en_q;
      assign app_p   = p_q;
      assign app_sel = sel_q;
    end else begin : g_comb
      assign app_en  = (state_q == ISSUE);
      assign app_p   = mul_p;
      assign app_sel = issue_sel;
    end
  endgenerate

  // Step counter and accumulator next state
  always_comb begin
    acc_d = acc_q;
    k_d   = k_q;
    if (accept) begin
      acc_d = 64'd0;
      k_d   = 4'd0;
    end else begin
      if (state_q == ISSUE) k_d = k_q + 4'd1;
      if (app_en) begin
        if (vec_q) acc_d[{app_sel[1:0], 4'b0000} +: 16] = app_p;
        else       acc_d = acc_q + ({48'd0, app_p} << {app_sel, 3'b000});
      end
    end
  end

  // Operand capture and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      vec_q <= 1'b0;
      k_q   <= 4'd0;
      acc_q <= 64'd0;
    end else begin
      if (accept) begin
        a_q   <= operand_a;
        b_q   <= operand_b;
        vec_q <= vec_mode;
      end
      k_q   <= k_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed bench for vedic_mul_seq_ctrl: one instance with a registered
// product path and one without, each driving a behavioural 8x8 multiplier.
module tb_vedic_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, vec_mode = 1'b0, out_ready = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        in_ready, out_valid, busy;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic [63:0] result;

  logic        z_in_valid = 1'b0, z_vec = 1'b0, z_out_ready = 1'b0;
  logic [31:0] z_a = '0, z_b = '0;
  logic        z_in_ready, z_out_valid, z_busy;
  logic [7:0]  z_mul_a, z_mul_b;
  logic [15:0] z_mul_p;
  logic [63:0] z_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam logic [31:0] SA [5] = '{32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h00000000, 32'h04030201};
  localparam logic [31:0] SB [5] = '{32'hFFFFFFFF, 32'h00010000, 32'h00000002, 32'hDEADBEEF, 32'h08070605};
  localparam logic [63:0] SE [5] = '{64'hFFFFFFFE00000001, 64'h0000000100000000, 64'h0000000100000000,
                                     64'h0, 64'h0020343D3C221005};
  localparam logic [31:0] VA [2] = '{32'h040302FF, 32'hFFFFFFFF};
  localparam logic [31:0] VB [2] = '{32'h100507FF, 32'h01010101};
  localparam logic [63:0] VE [2] = '{64'h0040000F000EFE01, 64'h00FF00FF00FF00FF};
  localparam logic [31:0] BA [4] = '{32'h04030201, 32'h040302FF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] BB [4] = '{32'h08070605, 32'h100507FF, 32'hFFFFFFFF, 32'h01010101};
  localparam logic        BV [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [63:0] BE [4] = '{64'h0020343D3C221005, 64'h0040000F000EFE01,
                                     64'hFFFFFFFE00000001, 64'h00FF00FF00FF00FF};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mul_p   = 16'(mul_a) * 16'(mul_b);
  assign z_mul_p = 16'(z_mul_a) * 16'(z_mul_b);

  vedic_mul_seq_ctrl #(.REG_PRODUCT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .vec_mode(vec_mode),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  vedic_mul_seq_ctrl #(.REG_PRODUCT(1'b0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .operand_a(z_a), .operand_b(z_b), .vec_mode(z_vec),
    .mul_a(z_mul_a), .mul_b(z_mul_b), .mul_p(z_mul_p),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .result(z_result), .busy(z_busy)
  );

  // Wait (bounded) for an accept on the main instance; t = accept cycle.
  // Returns just after the accept edge.
  task automatic wait_accept(input bit keep, output int t);
    bit found = 1'b0;
    t = -1;
    for (int i = 0; i < 60; i++) begin
      if (in_valid && in_ready) begin found = 1'b1; t = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL accept_timeout: got no accept want accept within 60 cycles"); end
    else begin
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for out_valid on the main instance; t = first valid cycle.
  task automatic wait_valid(output int t);
    bit found = 1'b0;
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; t = cyc; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL valid_timeout: got no out_valid want out_valid within 60 cycles"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_result: got %h want 0", result); end
    checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin errors++; $display("FAIL rst_mul: got %h/%h want 00/00", mul_a, mul_b); end
    checks++; if (z_in_ready !== 1'b1 || z_result !== 64'd0) begin errors++; $display("FAIL rst_z: got rdy %b res %h want 1/0", z_in_ready, z_result); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_scalar();
    for (int n = 0; n < 5; n++) begin
      int t0, t1;
      logic [7:0] ea, eb;
      operand_a = SA[n]; operand_b = SB[n]; vec_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      wait_accept(1'b0, t0);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        ea = 8'(SA[n] >> (8 * (k / 4)));
        eb = 8'(SB[n] >> (8 * (k % 4)));
        checks++;
        if (mul_a !== ea || mul_b !== eb) begin
          errors++; $display("FAIL scalar_sweep op%0d k%0d: got %h/%h want %h/%h", n, k, mul_a, mul_b, ea, eb);
        end
      end
      wait_valid(t1);
      checks++; if (t1 - t0 != 18) begin errors++; $display("FAIL scalar_latency op%0d: got %0d want 18", n, t1 - t0); end
      checks++; if (result !== SE[n]) begin errors++; $display("FAIL scalar_result op%0d: got %h want %h", n, result, SE[n]); end
      checks++;
      if (mul_a !== 8'd0 || mul_b !== 8'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL scalar_done_outputs op%0d: got mul %h/%h busy %b rdy %b want 00/00 1 0", n, mul_a, mul_b, busy, in_ready);
      end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL scalar_release op%0d: got vld %b rdy %b want 0 1", n, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_vector();
    for (int n = 0; n < 2; n++) begin
      int t0, t1;
      logic [7:0] ea, eb;
      operand_a = VA[n]; operand_b = VB[n]; vec_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      wait_accept(1'b0, t0);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        ea = 8'(VA[n] >> (8 * k));
        eb = 8'(VB[n] >> (8 * k));
        checks++;
        if (mul_a !== ea || mul_b !== eb) begin
          errors++; $display("FAIL vector_sweep op%0d k%0d: got %h/%h want %h/%h", n, k, mul_a, mul_b, ea, eb);
        end
      end
      wait_valid(t1);
      checks++; if (t1 - t0 != 6) begin errors++; $display("FAIL vector_latency op%0d: got %0d want 6", n, t1 - t0); end
      checks++; if (result !== VE[n]) begin errors++; $display("FAIL vector_result op%0d: got %h want %h", n, result, VE[n]); end
      out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int t0, t1;
    operand_a = VA[0]; operand_b = VB[0]; vec_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept(1'b0, t0);
    wait_valid(t1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== VE[0] || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d: got vld %b res %h rdy %b want 1 %h 0", i, out_valid, result, in_ready, VE[0]);
      end
      in_valid  = (i % 2 == 0);
      operand_a = $urandom;
      operand_b = $urandom;
      vec_mode  = ~vec_mode;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || result !== VE[0]) begin
      errors++; $display("FAIL bp_hold_end: got vld %b res %h want 1 %h", out_valid, result, VE[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got vld %b rdy %b busy %b want 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_single_handshake: got vld %b rdy %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop();
    int t0, t1;
    bit stray = 1'b0;
    operand_a = 32'h04030201; operand_b = 32'h08070605; vec_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept(1'b0, t0);
    repeat (8) @(negedge clk);
    checks++;
    if (mul_a !== 8'h02 || mul_b !== 8'h08) begin
      errors++; $display("FAIL midrst_step7: got %h/%h want 02/08", mul_a, mul_b);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL midrst_idle: got rdy %b vld %b busy %b res %h want 1 0 0 0", in_ready, out_valid, busy, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stray = 1'b1;
    end
    checks++; if (stray) begin errors++; $display("FAIL midrst_no_valid: got out_valid after abort want none"); end
    operand_a = 32'd3; operand_b = 32'd5; vec_mode = 1'b0; in_valid = 1'b1;
    wait_accept(1'b0, t0);
    wait_valid(t1);
    checks++; if (result !== 64'hF) begin errors++; $display("FAIL midrst_3x5: got %h want f", result); end
    checks++; if (t1 - t0 != 18) begin errors++; $display("FAIL midrst_latency: got %0d want 18", t1 - t0); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ta [4];
    int tv;
    out_ready = 1'b1; in_valid = 1'b1;
    operand_a = BA[0]; operand_b = BB[0]; vec_mode = BV[0];
    for (int n = 0; n < 4; n++) begin
      wait_accept(1'b1, ta[n]);
      if (n < 3) begin
        operand_a = BA[n+1]; operand_b = BB[n+1]; vec_mode = BV[n+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_valid(tv);
      checks++; if (result !== BE[n]) begin errors++; $display("FAIL b2b_result op%0d: got %h want %h", n, result, BE[n]); end
      if (n > 0) begin
        checks++;
        if (ta[n] - ta[n-1] != (BV[n-1] ? 7 : 19)) begin
          errors++; $display("FAIL b2b_spacing op%0d: got %0d want %0d", n, ta[n] - ta[n-1], BV[n-1] ? 7 : 19);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rdy %b vld %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reg0();
    logic [31:0] oa [3] = '{32'h040302FF, 32'h00010000, 32'h04030201};
    logic [31:0] ob [3] = '{32'h100507FF, 32'h00010000, 32'h08070605};
    logic        ov [3] = '{1'b1, 1'b0, 1'b0};
    logic [63:0] oe [3] = '{64'h0040000F000EFE01, 64'h0000000100000000, 64'h0020343D3C221005};
    for (int n = 0; n < 3; n++) begin
      int t0, t1;
      z_a = oa[n]; z_b = ob[n]; z_vec = ov[n]; z_in_valid = 1'b1; z_out_ready = 1'b0;
      t0 = -1;
      for (int i = 0; i < 20 && t0 < 0; i++) begin
        if (z_in_ready) t0 = cyc;
        else @(negedge clk);
      end
      @(posedge clk); #1;
      z_in_valid = 1'b0;
      t1 = -1;
      for (int i = 0; i < 40 && t1 < 0; i++) begin
        @(negedge clk);
        if (z_out_valid) t1 = cyc;
      end
      checks++;
      if (t0 < 0 || t1 < 0 || (t1 - t0) != (ov[n] ? 5 : 17)) begin
        errors++; $display("FAIL reg0_latency op%0d: got %0d want %0d", n, t1 - t0, ov[n] ? 5 : 17);
      end
      checks++; if (z_result !== oe[n]) begin errors++; $display("FAIL reg0_result op%0d: got %h want %h", n, z_result, oe[n]); end
      z_out_ready = 1'b1; @(negedge clk); z_out_ready = 1'b0;
      checks++;
      if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0 || z_busy !== 1'b0) begin
        errors++; $display("FAIL reg0_release op%0d: got rdy %b vld %b busy %b want 1 0 0", n, z_in_ready, z_out_valid, z_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_reg0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
